// File: rtl/pb_debouncer_pkg.sv
// Shared types and defaults for the multi-channel push-button debouncer.
package pb_debouncer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_UP = 3'd1,
    S_PE     = 3'd2,
    S_STABLE = 3'd3,
    S_CNT_DN = 3'd4,
    S_NE     = 3'd5
  } pb_fsm_e;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_COUNTER_WIDTH = 16;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;

  // Repeat counter must hold the larger of the two reload targets.
  function automatic int rpt_width(input int d, input int p);
    int m;
    m = (d > p) ? d : p;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: synchroniser, symmetric debounce FSM and counter.
// Auto-repeat is compiled in only when PB_DEBOUNCER_REPEAT_EN is defined.
module pb_debounce_ch
  import pb_debouncer_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic state_o,
  output logic pos_o,
  output logic neg_o,
  output logic rep_o
);

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     pb_sync;
  pb_fsm_e                  state_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pb_i};
  end

  assign pb_sync = sync_q[SYNC_STAGES-1];

  // Counter clears by default; only the counting states advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      cnt_q <= '0;
      case (state_q)
        S_IDLE:   if (pb_sync) state_q <= S_CNT_UP;
        S_CNT_UP: begin
          if (!pb_sync)   state_q <= S_IDLE;
          else if (&cnt_q) state_q <= S_PE;
          else            cnt_q   <= cnt_q + 1'b1;
        end
        S_PE:     state_q <= S_STABLE;
        S_STABLE: if (!pb_sync) state_q <= S_CNT_DN;
        S_CNT_DN: begin
          if (pb_sync)    state_q <= S_STABLE;
          else if (&cnt_q) state_q <= S_NE;
          else            cnt_q   <= cnt_q + 1'b1;
        end
        S_NE:     state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign state_o = (state_q == S_PE) || (state_q == S_STABLE) || (state_q == S_CNT_DN);
  assign pos_o   = (state_q == S_PE);
  assign neg_o   = (state_q == S_NE);

`ifdef PB_DEBOUNCER_REPEAT_EN
  localparam int RW = rpt_width(REPEAT_DELAY, REPEAT_PERIOD);

  logic [RW-1:0] rcnt_q, rcnt_d, rtgt;
  logic          first_q, first_d, rhit;

  // First pulse waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
  assign rtgt = first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign rhit = (state_q == S_STABLE) && (rcnt_q == rtgt);

  always_comb begin
    rcnt_d  = '0;
    first_d = 1'b1;
    if (state_q == S_STABLE) begin
      if (rhit) begin
        rcnt_d  = '0;
        first_d = 1'b0;
      end else begin
        rcnt_d  = rcnt_q + 1'b1;
        first_d = first_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q  <= '0;
      first_q <= 1'b1;
    end else begin
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
    end
  end

  assign rep_o = rhit;
`else
  assign rep_o = 1'b0;
`endif

endmodule

// File: rtl/pb_debouncer_multi.sv
// N_CH independent debounced push-button channels.
// Auto-repeat outputs are live only when PB_DEBOUNCER_REPEAT_EN is defined.
module pb_debouncer_multi
  import pb_debouncer_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_posedge,
  output logic [N_CH-1:0] pb_negedge,
  output logic [N_CH-1:0] pb_repeat
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_debounce_ch #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pb_i    (pb[g]),
      .state_o (pb_state[g]),
      .pos_o   (pb_posedge[g]),
      .neg_o   (pb_negedge[g]),
      .rep_o   (pb_repeat[g])
    );
  end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Bench for pb_debouncer_multi: vector table, directed corner cases and a
// random run against a run-length reference model.
module tb_pb_debouncer_multi;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int SS  = 2;
  localparam int RD  = 20;
  localparam int RP  = 6;
  localparam int WIN = 1 << CW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] pb  = '0;
  logic [NCH-1:0] pb_state, pb_posedge, pb_negedge, pb_repeat;

  int tests  = 0;
  int failed = 0;

  pb_debouncer_multi #(
    .N_CH(NCH), .COUNTER_WIDTH(CW), .SYNC_STAGES(SS),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .pb(pb),
    .pb_state(pb_state), .pb_posedge(pb_posedge),
    .pb_negedge(pb_negedge), .pb_repeat(pb_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Level toggles after WIN+1 consecutive synchronised samples opposite to it;
  // the sample right after a toggle is ignored (pulse cycle).
  bit dq [NCH][$];
  int lvl [NCH], run [NCH], hold [NCH], stc [NCH];
  logic [NCH-1:0] m_st, m_pe, m_ne, m_rp;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      dq[i] = {};
      for (int k = 0; k < SS; k++) dq[i].push_back(1'b0);
      lvl[i] = 0; run[i] = 0; hold[i] = 0; stc[i] = 0;
    end
    m_st = '0; m_pe = '0; m_ne = '0; m_rp = '0;
  endtask

  task automatic model_step();
    bit vis;
    for (int i = 0; i < NCH; i++) begin
      vis = dq[i].pop_front();
      dq[i].push_back(pb[i]);
      m_pe[i] = 1'b0;
      m_ne[i] = 1'b0;
      if (hold[i] != 0) begin
        hold[i] = 0;
        run[i]  = 0;
      end else if (int'(vis) != lvl[i]) begin
        run[i]++;
        if (run[i] == WIN + 1) begin
          lvl[i] = int'(vis);
          if (vis) m_pe[i] = 1'b1; else m_ne[i] = 1'b1;
          hold[i] = 1;
          run[i]  = 0;
        end
      end else begin
        run[i] = 0;
      end
      if (lvl[i] == 1 && hold[i] == 0 && run[i] == 0) stc[i]++;
      else stc[i] = 0;
`ifdef PB_DEBOUNCER_REPEAT_EN
      m_rp[i] = (stc[i] >= RD) && (((stc[i] - RD) % RP) == 0);
`else
      m_rp[i] = 1'b0;
`endif
      m_st[i] = (lvl[i] == 1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0] pb;
    int             n;
    logic [NCH-1:0] st, pe, ne;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int cnt, at, lowst, rcnt;
    int hit [3];
    int holdc [NCH];

    tbl[0]  = '{4'b0001, 18, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0000, 18, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1001, 18, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1001,  1, 4'b1001, 4'b1001, 4'b0000};
    tbl[8]  = '{4'b1001,  1, 4'b1001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 18, 4'b1001, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1001};
    tbl[11] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b0000};

    // reset state
    edges(2);
    chk("reset_state", pb_state, 0);
    chk("reset_pulses", {pb_posedge, pb_negedge, pb_repeat}, 0);
    rst = 1'b0;

    foreach (tbl[r]) begin
      pb = tbl[r].pb;
      edges(tbl[r].n);
      chk($sformatf("tbl%0d_state", r), pb_state, tbl[r].st);
      chk($sformatf("tbl%0d_pos", r), pb_posedge, tbl[r].pe);
      chk($sformatf("tbl%0d_neg", r), pb_negedge, tbl[r].ne);
    end

    // bouncy press on ch1: 5-cycle toggles for 40 cycles, then hold
    cnt = 0; at = 0;
    for (int c = 0; c < 40; c++) begin
      pb[1] = ((c / 5) % 2) == 0;
      edges(1);
      if (pb_posedge[1]) cnt++;
    end
    pb[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      edges(1);
      if (pb_posedge[1]) begin cnt++; at = k; end
    end
    chk("bounce_pos_count", cnt, 1);
    chk("bounce_pos_edge", at, 19);
    chk("bounce_state", pb_state, 4'b0010);
    pb[1] = 1'b0;
    edges(25);

    // release glitch on ch2
    pb[2] = 1'b1;
    edges(25);
    chk("glitch_pressed", pb_state[2], 1);
    cnt = 0; lowst = 0;
    pb[2] = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      if (k == 9) pb[2] = 1'b1;
      edges(1);
      if (pb_negedge[2]) cnt++;
      if (!pb_state[2]) lowst++;
    end
    chk("glitch_no_neg", cnt, 0);
    chk("glitch_state_low_cycles", lowst, 0);
    pb[2] = 1'b0;
    edges(25);
    chk("glitch_released", pb_state, 0);

    // asynchronous reset mid-hold
    pb[0] = 1'b1;
    edges(25);
    chk("rst_pre_state", pb_state[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {pb_state, pb_posedge, pb_negedge, pb_repeat}, 0);
    pb[0] = 1'b0;
    edges(3);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      edges(1);
      if ({pb_state, pb_posedge, pb_negedge, pb_repeat} != 0) cnt++;
    end
    chk("rst_after_idle", cnt, 0);

`ifdef PB_DEBOUNCER_REPEAT_EN
    // auto-repeat on ch0
    rcnt = 0;
    pb[0] = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      edges(1);
      if (pb_repeat[0]) begin
        if (rcnt < 3) hit[rcnt] = k;
        rcnt++;
      end
      if (pb_repeat[3:1] != 0) rcnt += 100;
    end
    chk("rep_count", rcnt, 3);
    chk("rep_edge0", hit[0], 39);
    chk("rep_edge1", hit[1], 45);
    chk("rep_edge2", hit[2], 51);
    pb[0] = 1'b0;
    rcnt = 0;
    for (int k = 0; k < 40; k++) begin
      edges(1);
      if (pb_repeat != 0) rcnt++;
    end
    chk("rep_stop", rcnt, 0);
`endif

    // randomized run against the reference model
    rst = 1'b1;
    pb  = '0;
    edges(2);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NCH; i++) holdc[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("rand_state", pb_state, m_st);
      chk("rand_pulses", {pb_posedge, pb_negedge, pb_repeat}, {m_pe, m_ne, m_rp});
      for (int i = 0; i < NCH; i++) begin
        holdc[i]--;
        if (holdc[i] <= 0) begin
          pb[i] = ~pb[i];
          holdc[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 12) : $urandom_range(15, 60);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
